// File: rtl/rv.sv
// -----------------------------------------------------------------------------
// Package rv
// Purpose : Shared RV32I definitions for the decode/operand-fetch stage:
//           default datapath widths, major-opcode field constants, the decoded
//           instruction enumeration and the immediate-format enumeration.
// Contents:
//   RV_XLEN / RV_REG_AW  default datapath width / register index width
//   OPC_*                7-bit major opcode values (instr[6:0])
//   RV32_INSTRUCTION     decoded operation, ILLEGAL for unrecognised encodings
//   imm_fmt_e            immediate layout selected from the major opcode
// -----------------------------------------------------------------------------
package rv;

    localparam int RV_XLEN   = 32;
    localparam int RV_REG_AW = 5;

    // Major opcode field values
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [5:0] {
        ILLEGAL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } RV32_INSTRUCTION;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/rv_regfile.sv
// -----------------------------------------------------------------------------
// Module rv_regfile
// Purpose : Integer register file, 2**REG_AW entries of XLEN bits, x0 reads 0.
//           Two asynchronous read ports, one synchronous write port.
//           Asynchronous active-low reset clears every entry.
// Ports   :
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_we       in   write enable
//   i_wa       in   write index (writes to index 0 are dropped)
//   i_wd       in   write data
//   i_ra1      in   read index, port 1
//   i_ra2      in   read index, port 2
//   o_rd1      out  read data, port 1
//   o_rd2      out  read data, port 2
// -----------------------------------------------------------------------------
module rv_regfile
    import rv::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int REG_AW = RV_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [XLEN-1:0]   i_wd,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    output logic [XLEN-1:0]   o_rd1,
    output logic [XLEN-1:0]   o_rd2
);

    localparam int NREG = 2 ** REG_AW;

    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // x0 is forced to zero on the read side as well, so it never depends
    // on the reset value of entry 0.
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// Module decode_stage
// Purpose : RV32I decode / operand-fetch stage in front of the ALU. Accepts an
//           instruction word with valid/ready, decodes it to RV32_INSTRUCTION,
//           builds the sign-extended immediate, reads rs1/rs2 from the register
//           file it owns, and holds the result in a single registered slot.
// Build option:
//   DECODE_WB_BYPASS_EN  defined : writeback data is forwarded to a matching
//                                  operand read in the same cycle, no stall.
//                        undefined: a same-cycle writeback hit on rs1/rs2
//                                  stalls the input for that cycle.
// Ports   :
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           drop held output; blocks accept this cycle
//   in_valid/in_ready               fetch handshake
//   in_instr, in_pc                 instruction word and its address
//   wb_en, wb_rd, wb_data           register writeback port
//   out_valid/out_ready             ALU handshake
//   out_op1, out_op2                rs1 / rs2 values
//   out_imm                         sign-extended immediate (0 for R-type)
//   out_opcode, out_illegal         decoded operation, unrecognised encoding
//   out_rd, out_pc                  destination index (0 if none), pc
// -----------------------------------------------------------------------------
module decode_stage
    import rv::*;
#(
    parameter int XLEN   = RV_XLEN,
    parameter int REG_AW = RV_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_imm,
    output RV32_INSTRUCTION   out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd_field;

    assign w_opc      = in_instr[6:0];
    assign w_f3       = in_instr[14:12];
    assign w_f7       = in_instr[31:25];
    assign w_rs1      = REG_AW'(in_instr[19:15]);
    assign w_rs2      = REG_AW'(in_instr[24:20]);
    assign w_rd_field = REG_AW'(in_instr[11:7]);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    RV32_INSTRUCTION w_op;
    imm_fmt_e        w_fmt;
    logic            w_has_rd;

    always_comb begin
        w_op     = ILLEGAL;
        w_fmt    = IMM_R;
        w_has_rd = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_op     = LUI;
                w_fmt    = IMM_U;
                w_has_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_op     = AUIPC;
                w_fmt    = IMM_U;
                w_has_rd = 1'b1;
            end
            OPC_JAL: begin
                w_op     = JAL;
                w_fmt    = IMM_J;
                w_has_rd = 1'b1;
            end
            OPC_JALR: begin
                w_fmt    = IMM_I;
                w_has_rd = 1'b1;
                if (w_f3 == 3'b000) w_op = JALR;
            end
            OPC_BRANCH: begin
                w_fmt = IMM_B;
                case (w_f3)
                    3'b000:  w_op = BEQ;
                    3'b001:  w_op = BNE;
                    3'b100:  w_op = BLT;
                    3'b101:  w_op = BGE;
                    3'b110:  w_op = BLTU;
                    3'b111:  w_op = BGEU;
                    default: w_op = ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                w_fmt    = IMM_I;
                w_has_rd = 1'b1;
                case (w_f3)
                    3'b000:  w_op = LB;
                    3'b001:  w_op = LH;
                    3'b010:  w_op = LW;
                    3'b100:  w_op = LBU;
                    3'b101:  w_op = LHU;
                    default: w_op = ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                w_fmt = IMM_S;
                case (w_f3)
                    3'b000:  w_op = SB;
                    3'b001:  w_op = SH;
                    3'b010:  w_op = SW;
                    default: w_op = ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                w_fmt    = IMM_I;
                w_has_rd = 1'b1;
                case (w_f3)
                    3'b000: w_op = ADDI;
                    3'b010: w_op = SLTI;
                    3'b011: w_op = SLTIU;
                    3'b100: w_op = XORI;
                    3'b110: w_op = ORI;
                    3'b111: w_op = ANDI;
                    // Shift-immediates reuse funct7 to pick logical/arithmetic
                    3'b001: if (w_f7 == 7'b0000000) w_op = SLLI;
                    3'b101: begin
                        if (w_f7 == 7'b0000000)      w_op = SRLI;
                        else if (w_f7 == 7'b0100000) w_op = SRAI;
                    end
                    default: w_op = ILLEGAL;
                endcase
            end
            OPC_OP: begin
                w_fmt    = IMM_R;
                w_has_rd = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_op = ADD;
                        3'b001:  w_op = SLL;
                        3'b010:  w_op = SLT;
                        3'b011:  w_op = SLTU;
                        3'b100:  w_op = XOR;
                        3'b101:  w_op = SRL;
                        3'b110:  w_op = OR;
                        default: w_op = AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000)      w_op = SUB;
                    else if (w_f3 == 3'b101) w_op = SRA;
                end
            end
            OPC_MISC_MEM: begin
                w_fmt = IMM_I;
                if (w_f3 == 3'b000) w_op = FENCE;
            end
            OPC_SYSTEM: begin
                w_fmt = IMM_I;
                if (in_instr == 32'h0000_0073)      w_op = ECALL;
                else if (in_instr == 32'h0010_0073) w_op = EBREAK;
            end
            default: begin
                w_op  = ILLEGAL;
                w_fmt = IMM_R;
            end
        endcase
    end

    logic              w_illegal;
    logic [REG_AW-1:0] w_rd;

    assign w_illegal = (w_op == ILLEGAL);
    // An illegal encoding never names a destination, even if its major
    // opcode normally writes rd.
    assign w_rd      = (w_has_rd && !w_illegal) ? w_rd_field : '0;

    // ------------------------------------------------------------------
    // Immediate generation (format chosen by major opcode)
    // ------------------------------------------------------------------
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends when XLEN is wider than 32
    assign w_imm = XLEN'(w_imm32);

    // ------------------------------------------------------------------
    // Register file and same-cycle writeback hazard
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;

    rv_regfile #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (wb_en),
        .i_wa  (wb_rd),
        .i_wd  (wb_data),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2)
    );

    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_stall;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    assign w_wb_hit1 = wb_en && (wb_rd != '0) && (wb_rd == w_rs1);
    assign w_wb_hit2 = wb_en && (wb_rd != '0) && (wb_rd == w_rs2);

`ifdef DECODE_WB_BYPASS_EN
    assign w_stall = 1'b0;
    assign w_op1   = w_wb_hit1 ? wb_data : w_rf_rd1;
    assign w_op2   = w_wb_hit2 ? wb_data : w_rf_rd2;
`else
    // The register file only sees the write at the edge, so hold the
    // instruction one cycle and read the committed value next cycle.
    assign w_stall = w_wb_hit1 || w_wb_hit2;
    assign w_op1   = w_rf_rd1;
    assign w_op2   = w_rf_rd2;
`endif

    // ------------------------------------------------------------------
    // Handshake and output slot
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_imm;
    RV32_INSTRUCTION r_opcode;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0] r_pc;
    logic            r_illegal;
    logic            w_ready;
    logic            w_accept;

    // flush blocks accept, so a flush always wins over a new instruction
    assign w_ready  = (!r_valid || out_ready) && !w_stall && !flush;
    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_opcode  <= ILLEGAL;
            r_rd      <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_imm     <= w_imm;
                r_opcode  <= w_op;
                r_rd      <= w_rd;
                r_pc      <= in_pc;
                r_illegal <= w_illegal;
            end else if (flush || out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_ready;
    assign out_valid   = r_valid;
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_imm     = r_imm;
    assign out_opcode  = r_opcode;
    assign out_rd      = r_rd;
    assign out_pc      = r_pc;
    assign out_illegal = r_illegal;

endmodule
